// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one 8-bit RAM host port between two
// strobe-driven requesters, with fixed-length accesses and DONE pulses.
module ram_port_arbiter #(
    parameter int ADDR_W        = 24,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic [ADDR_W-1:0] S0_ADDR,
    input  logic [7:0]        S0_DIN,
    input  logic              S0_OE_n,
    input  logic              S0_WE_n,
    input  logic              S0_RFSH_n,
    output logic [7:0]        S0_DOUT,
    output logic              S0_DONE,
    input  logic [ADDR_W-1:0] S1_ADDR,
    input  logic [7:0]        S1_DIN,
    input  logic              S1_OE_n,
    input  logic              S1_WE_n,
    input  logic              S1_RFSH_n,
    output logic [7:0]        S1_DOUT,
    output logic              S1_DONE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [7:0]        M_DIN,
    output logic              M_OE_n,
    output logic              M_WE_n,
    output logic              M_RFSH_n,
    input  logic [7:0]        M_DOUT
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic [1:0]        prev_q;
    logic [1:0]        pend_q, pend_d;
    logic [1:0]        done_q, done_d;
    logic [7:0]        dout0_q, dout0_d;
    logic [7:0]        dout1_q, dout1_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        mdin_q, mdin_d;
    logic              moe_q, moe_d;
    logic              mwe_q, mwe_d;
    logic              mrf_q;

    logic [1:0]        act_n;
    logic [1:0]        fall;
    logic [1:0]        take;
    logic              sel;
    logic              sel_wr;

    assign act_n[0] = S0_OE_n & S0_WE_n;
    assign act_n[1] = S1_OE_n & S1_WE_n;
    assign fall     = prev_q & ~act_n;

    // Arbitration, access sequencing and request bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        done_d  = 2'b00;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        maddr_d = maddr_q;
        mdin_d  = mdin_q;
        moe_d   = moe_q;
        mwe_d   = mwe_q;
        take    = 2'b00;
        sel     = 1'b0;
        sel_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    sel     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    sel_wr  = sel ? ~S1_WE_n : ~S0_WE_n;
                    take[sel] = 1'b1;
                    gnt_d   = sel;
                    last_d  = sel;
                    wr_d    = sel_wr;
                    maddr_d = sel ? S1_ADDR : S0_ADDR;
                    mdin_d  = sel ? S1_DIN : S0_DIN;
                    moe_d   = sel_wr;
                    mwe_d   = ~sel_wr;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    moe_d   = 1'b1;
                    mwe_d   = 1'b1;
                    maddr_d = '0;
                    mdin_d  = '0;
                    done_d[gnt_q] = 1'b1;
                    if (!wr_q) begin
                        if (gnt_q) dout1_d = M_DOUT;
                        else       dout0_d = M_DOUT;
                    end
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            pend_d[i] = fall[i] | (pend_q[i] & ~take[i] & ~act_n[i]);
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            prev_q  <= 2'b11;
            pend_q  <= 2'b00;
            done_q  <= 2'b00;
            dout0_q <= '0;
            dout1_q <= '0;
            maddr_q <= '0;
            mdin_q  <= '0;
            moe_q   <= 1'b1;
            mwe_q   <= 1'b1;
            mrf_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            prev_q  <= act_n;
            pend_q  <= pend_d;
            done_q  <= done_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            maddr_q <= maddr_d;
            mdin_q  <= mdin_d;
            moe_q   <= moe_d;
            mwe_q   <= mwe_d;
            mrf_q   <= S0_RFSH_n & S1_RFSH_n;
        end
    end

    assign S0_DOUT  = dout0_q;
    assign S1_DOUT  = dout1_q;
    assign S0_DONE  = done_q[0];
    assign S1_DONE  = done_q[1];
    assign M_ADDR   = maddr_q;
    assign M_DIN    = mdin_q;
    assign M_OE_n   = moe_q;
    assign M_WE_n   = mwe_q;
    assign M_RFSH_n = mrf_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios with literal timing
// expectations plus randomized traffic against a behavioural model.
module tb_ram_port_arbiter;

    localparam int AW  = 24;
    localparam int ACC = 4;

    logic          CLK = 1'b0;
    logic          RESET_n;
    logic [AW-1:0] addr [2];
    logic [7:0]    din  [2];
    logic [1:0]    oe_n, we_n, rf_n;
    logic [7:0]    M_DOUT;
    logic [7:0]    S0_DOUT, S1_DOUT;
    logic          S0_DONE, S1_DONE;
    logic [AW-1:0] M_ADDR;
    logic [7:0]    M_DIN;
    logic          M_OE_n, M_WE_n, M_RFSH_n;

    ram_port_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(ACC)) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .S0_ADDR(addr[0]), .S0_DIN(din[0]), .S0_OE_n(oe_n[0]),
        .S0_WE_n(we_n[0]), .S0_RFSH_n(rf_n[0]),
        .S0_DOUT(S0_DOUT), .S0_DONE(S0_DONE),
        .S1_ADDR(addr[1]), .S1_DIN(din[1]), .S1_OE_n(oe_n[1]),
        .S1_WE_n(we_n[1]), .S1_RFSH_n(rf_n[1]),
        .S1_DOUT(S1_DOUT), .S1_DONE(S1_DONE),
        .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_OE_n(M_OE_n),
        .M_WE_n(M_WE_n), .M_RFSH_n(M_RFSH_n), .M_DOUT(M_DOUT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: requests queue as pending flags, the port is
    // either free, busy for a number of strobe cycles, or recovering.
    bit [1:0]      mp, mprev, mact, mfall, mtook;
    bit            mbusy, mrec, mlast, mown, mwr;
    int            mleft, mw;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din;
    logic [7:0]    e_dout [2];
    bit            e_oe, e_we, e_rf;
    bit [1:0]      e_done;

    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            mp = 0; mprev = 2'b11; mbusy = 0; mrec = 0; mlast = 1;
            mown = 0; mwr = 0; mleft = 0;
            e_addr = 0; e_din = 0; e_dout[0] = 0; e_dout[1] = 0;
            e_oe = 1; e_we = 1; e_rf = 1; e_done = 0;
        end else begin
            mact  = oe_n & we_n;
            mfall = mprev & ~mact;
            mtook = 0;
            e_done = 0;
            if (mbusy) begin
                mleft = mleft - 1;
                if (mleft == 0) begin
                    e_oe = 1; e_we = 1; e_addr = 0; e_din = 0;
                    e_done[mown] = 1;
                    if (!mwr) e_dout[mown] = M_DOUT;
                    mbusy = 0;
                    mrec = 1;
                end
            end else if (mrec) begin
                mrec = 0;
            end else if (mp != 0) begin
                mw = (mp == 2'b11) ? int'(!mlast) : int'(mp[1]);
                mtook[mw] = 1;
                mlast = mw[0];
                mown  = mw[0];
                mwr   = !we_n[mw];
                e_addr = addr[mw];
                e_din  = din[mw];
                e_oe = mwr;
                e_we = !mwr;
                mleft = ACC;
                mbusy = 1;
            end
            for (int i = 0; i < 2; i++)
                mp[i] = mfall[i] | (mp[i] & !mtook[i] & !mact[i]);
            mprev = mact;
            e_rf = rf_n[0] & rf_n[1];
        end
    end

    // Compare every cycle against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("M_ADDR", 32'(M_ADDR), 32'(e_addr));
            chk("M_DIN", 32'(M_DIN), 32'(e_din));
            chk("M_OE_n", 32'(M_OE_n), 32'(e_oe));
            chk("M_WE_n", 32'(M_WE_n), 32'(e_we));
            chk("M_RFSH_n", 32'(M_RFSH_n), 32'(e_rf));
            chk("S0_DONE", 32'(S0_DONE), 32'(e_done[0]));
            chk("S1_DONE", 32'(S1_DONE), 32'(e_done[1]));
            chk("S0_DOUT", 32'(S0_DOUT), 32'(e_dout[0]));
            chk("S1_DOUT", 32'(S1_DOUT), 32'(e_dout[1]));
        end
    end

    logic [15:0]   v_oe, v_we, v_d0, v_d1, v_rf;
    logic [AW-1:0] a_addr;
    logic [7:0]    a_din;

    // Record n cycles of outputs; optional S1 read pulse and refresh window
    task automatic run(input int n, input int s1lo, input int s1hi,
                       input int rflo, input int rfhi);
        v_oe = '1; v_we = '1; v_d0 = '0; v_d1 = '0; v_rf = '1;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            v_oe[k-1] = M_OE_n;
            v_we[k-1] = M_WE_n;
            v_d0[k-1] = S0_DONE;
            v_d1[k-1] = S1_DONE;
            v_rf[k-1] = M_RFSH_n;
            if (k == 3) begin
                a_addr = M_ADDR;
                a_din  = M_DIN;
            end
            if (k == s1lo) oe_n[1] = 1'b0;
            if (k == s1hi) oe_n[1] = 1'b1;
            if (k == rflo) rf_n[1] = 1'b0;
            if (k == rfhi) rf_n[1] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tie(input logic [7:0] d);
        addr[0] = 24'h000AAA;
        addr[1] = 24'h000BBB;
        M_DOUT  = d;
        oe_n    = 2'b00;
        run(16, 0, 0, 0, 0);
        oe_n    = 2'b11;
        idle(3);
    endtask

    int kk;

    initial begin
        RESET_n = 1'b0;
        oe_n = 2'b11; we_n = 2'b11; rf_n = 2'b11;
        addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
        M_DOUT = '0;
        idle(2);
        chk("rst M_OE_n", 32'(M_OE_n), 32'h1);
        chk("rst M_WE_n", 32'(M_WE_n), 32'h1);
        chk("rst M_RFSH_n", 32'(M_RFSH_n), 32'h1);
        chk("rst M_ADDR", 32'(M_ADDR), 32'h0);
        chk("rst DONE", 32'({S0_DONE, S1_DONE}), 32'h0);
        chk("rst DOUT", 32'({S0_DOUT, S1_DOUT}), 32'h0);
        RESET_n = 1'b1;
        chk_en = 1;
        idle(2);

        addr[0] = 24'h012345;
        M_DOUT  = 8'hA5;
        oe_n[0] = 1'b0;
        run(8, 0, 0, 0, 0);
        oe_n[0] = 1'b1;
        chk("rd oe", 32'(v_oe), 32'hFFE1);
        chk("rd we", 32'(v_we), 32'hFFFF);
        chk("rd done0", 32'(v_d0), 32'h0020);
        chk("rd done1", 32'(v_d1), 32'h0000);
        chk("rd addr", 32'(a_addr), 32'h012345);
        chk("rd dout0", 32'(S0_DOUT), 32'hA5);
        idle(3);

        addr[1] = 24'h000100;
        din[1]  = 8'h3C;
        we_n[1] = 1'b0;
        run(8, 0, 0, 0, 0);
        we_n[1] = 1'b1;
        chk("wr we", 32'(v_we), 32'hFFE1);
        chk("wr oe", 32'(v_oe), 32'hFFFF);
        chk("wr done1", 32'(v_d1), 32'h0020);
        chk("wr done0", 32'(v_d0), 32'h0000);
        chk("wr din", 32'(a_din), 32'h3C);
        chk("wr dout1", 32'(S1_DOUT), 32'h00);
        idle(3);

        tie(8'h5A);
        chk("tie1 done0", 32'(v_d0), 32'h0020);
        chk("tie1 done1", 32'(v_d1), 32'h0800);
        chk("tie1 oe", 32'(v_oe), 32'hF861);
        chk("tie1 dout1", 32'(S1_DOUT), 32'h5A);
        tie(8'h66);
        chk("tie2 done0", 32'(v_d0), 32'h0020);
        chk("tie2 done1", 32'(v_d1), 32'h0800);
        oe_n[0] = 1'b0;
        run(8, 0, 0, 0, 0);
        oe_n[0] = 1'b1;
        idle(3);
        tie(8'h77);
        chk("tie3 done1", 32'(v_d1), 32'h0020);
        chk("tie3 done0", 32'(v_d0), 32'h0800);

        oe_n[0] = 1'b0;
        run(12, 2, 3, 0, 0);
        oe_n[0] = 1'b1;
        chk("abort done1", 32'(v_d1), 32'h0000);
        chk("abort done0", 32'(v_d0), 32'h0020);
        chk("abort oe", 32'(v_oe), 32'hFFE1);
        idle(3);

        addr[0] = 24'h00F00D;
        oe_n[0] = 1'b0;
        idle(3);
        #2 RESET_n = 1'b0;
        #1;
        chk("mid-rst M_OE_n", 32'(M_OE_n), 32'h1);
        chk("mid-rst M_ADDR", 32'(M_ADDR), 32'h0);
        chk("mid-rst DONE", 32'({S0_DONE, S1_DONE}), 32'h0);
        oe_n[0] = 1'b1;
        @(negedge CLK);
        #2 RESET_n = 1'b1;
        run(10, 0, 0, 0, 0);
        chk("post-rst done0", 32'(v_d0), 32'h0000);
        chk("post-rst oe", 32'(v_oe), 32'hFFFF);

        M_DOUT  = 8'hC3;
        oe_n[0] = 1'b0;
        run(8, 0, 0, 1, 4);
        oe_n[0] = 1'b1;
        chk("rf rfsh", 32'(v_rf), 32'hFFF1);
        chk("rf oe", 32'(v_oe), 32'hFFE1);
        chk("rf done0", 32'(v_d0), 32'h0020);
        idle(3);

        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (oe_n[i] & we_n[i]) begin
                    addr[i] = 24'($urandom);
                    din[i]  = 8'($urandom);
                    if ($urandom_range(0, 5) == 0) begin
                        kk = int'($urandom_range(1, 3));
                        oe_n[i] = ~kk[0];
                        we_n[i] = ~kk[1];
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    oe_n[i] = 1'b1;
                    we_n[i] = 1'b1;
                end
            end
            rf_n   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            M_DOUT = 8'($urandom);
        end
        oe_n = 2'b11; we_n = 2'b11; rf_n = 2'b11;
        idle(20);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
